noc_requant_stage: RTL
======================

NOC_REQUANT_STAGE -- requirements
Module: noc_requant_stage

Interface
REQ-001 Parameter IN_W, 32, signed accumulator width from the MM core.
REQ-002 Parameter OUT_W, 8, signed requantized output width.
REQ-003 Parameter MULT_W, 16, signed fixed-point multiplier width.
REQ-004 Parameter NUM_ELEMS, 4096, elements per job; legal range 1 to 2^20.
REQ-005 clk in 1: single clock; every register updates on its rising edge.
REQ-006 rst in 1: synchronous, active-high reset.
REQ-007 start in 1: one-cycle job start pulse from the control FSM.
REQ-008 cfg_mult in MULT_W: signed multiplier.
REQ-009 cfg_shift in 6: right-shift amount; legal range 0..47.
REQ-010 cfg_zp in OUT_W: signed output zero point.
REQ-011 s_tdata in IN_W, s_tvalid in 1, s_tlast in 1, s_tready out 1: input stream from the MM core.
REQ-012 m_tdata out OUT_W, m_tvalid out 1, m_tlast out 1, m_tready in 1: output stream to GELU.
REQ-013 busy out 1, done out 1 (one-cycle pulse), error out 1 (sticky).

Function
REQ-014 States: IDLE, RUN, FLUSH, DONE.
REQ-015 IDLE->RUN on start; cfg_mult, cfg_shift and cfg_zp are latched on that cycle, the element counter is cleared and error is cleared.
REQ-016 In RUN, s_tready = pipeline-advance AND (count < NUM_ELEMS).
- pipeline-advance = NOT(output register valid AND NOT m_tready).
REQ-017 An input beat is accepted when s_tvalid AND s_tready; count increments by 1 per accepted beat.
REQ-018 RUN->FLUSH on acceptance of beat number NUM_ELEMS-1 (zero-based).
REQ-019 FLUSH->DONE when the last output beat is accepted (m_tvalid AND m_tready AND m_tlast).
REQ-020 DONE->IDLE unconditionally on the next cycle; done = 1 only while in DONE.
REQ-021 The datapath has two register stages.
- Stage 1: prod = s_tdata * mult, signed, IN_W+MULT_W bits.
- Stage 2: round, shift, add zero point, saturate.
- Latency: accepted beat appears on m_tdata 2 cycles later when m_tready stays 1.
REQ-022 Rounding: if shift > 0, r = (prod + 2^(shift-1)) >>> shift (arithmetic); if shift = 0, r = prod; no intermediate overflow is permitted.
REQ-023 Output: y = r + zp, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 m_tlast = 1 only on the output beat derived from input beat NUM_ELEMS-1.
REQ-025 Backpressure: when m_tready = 0 with m_tvalid = 1, all stages hold, no beat is dropped or duplicated, and m_tdata stays stable.
REQ-026 error is set, and stays set until the next start, in either case:
- s_tlast = 1 on an accepted beat other than NUM_ELEMS-1;
- s_tlast = 0 on beat NUM_ELEMS-1.
The job still completes on the count, not on s_tlast.
REQ-027 start in any state other than IDLE is ignored.
REQ-028 busy = 1 in RUN and FLUSH.
REQ-029 If start and an accepted beat occur in the same cycle in IDLE, the beat is not accepted, because s_tready = 0 in IDLE.

Reset
REQ-030 On rst, the next state is IDLE and the pipeline valids are cleared.
- Outputs: s_tready, m_tvalid, m_tlast, busy, done and error = 0.
- m_tdata = 0, count = 0.
REQ-031 rst mid-job aborts the job immediately: no done pulse, and in-flight beats are discarded.

Structure
REQ-032 noc_pkg holds the widths, the FSM state enum and the saturation limits as localparams shared with the control FSM and the GELU stage.
REQ-033 The arithmetic lives in one sub-module, requant_core: a 2-stage multiply/round/saturate datapath with a shared enable; the top level holds the FSM, counter and handshake.

Verification
REQ-034 mult = 16384, shift = 14, zp = 0; inputs 100, -100, 3 -> outputs 100, -100, 3, done pulse after the last output.
REQ-035 mult = 1, shift = 1, zp = 0; inputs 1, 3, -1, -3 -> outputs 1, 2, 0, -1 (round half up).
REQ-036 mult = 1, shift = 0, zp = 10; inputs 200, -200, 117 -> outputs 127, -128, 127 (saturation).
REQ-037 NUM_ELEMS = 8, m_tready toggles 1-0-0-1 -> exactly 8 outputs in order, m_tlast on the 8th only, data stable while stalled.
REQ-038 NUM_ELEMS = 4, s_tlast on beat 1 -> error = 1; 4 outputs are still produced, done pulses, and error clears on the next start.
REQ-039 rst asserted after 2 of 8 beats -> m_tvalid = 0 and busy = 0 the next cycle, no done pulse, and a fresh job then completes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared widths, control FSM state encoding and output saturation limits
// for the requantization stage and its neighbours in the NoC datapath.
package noc_pkg;

    localparam int NOC_IN_W    = 32;
    localparam int NOC_OUT_W   = 8;
    localparam int NOC_MULT_W  = 16;
    localparam int NOC_SHIFT_W = 6;

    function automatic longint noc_sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint noc_sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint NOC_SAT_MAX = noc_sat_hi(NOC_OUT_W);
    localparam longint NOC_SAT_MIN = noc_sat_lo(NOC_OUT_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } noc_state_t;

endpackage

// File: rtl/requant_core.sv
// Two-stage requantizer: stage 1 multiplies, stage 2 rounds, shifts, adds the
// zero point and saturates. Both stages advance together on i_en.
module requant_core
    import noc_pkg::*;
#(
    parameter int IN_W   = NOC_IN_W,
    parameter int OUT_W  = NOC_OUT_W,
    parameter int MULT_W = NOC_MULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic signed [IN_W-1:0]   i_data,
    input  logic signed [MULT_W-1:0] i_mult,
    input  logic [NOC_SHIFT_W-1:0]   i_shift,
    input  logic signed [OUT_W-1:0]  i_zp,
    output logic signed [OUT_W-1:0]  o_data,
    output logic                     o_valid,
    output logic                     o_last
);

    localparam int P_W = IN_W + MULT_W;
    localparam logic signed [P_W+1:0] SAT_HI = (P_W + 2)'(noc_sat_hi(OUT_W));
    localparam logic signed [P_W+1:0] SAT_LO = (P_W + 2)'(noc_sat_lo(OUT_W));

    logic signed [P_W-1:0]   r_prod;
    logic                    r_v1;
    logic                    r_l1;
    logic signed [P_W:0]     w_half;
    logic signed [P_W:0]     w_rnd;
    logic signed [P_W:0]     w_r;
    logic signed [P_W+1:0]   w_y;
    logic signed [OUT_W-1:0] w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
        end else if (i_en) begin
            r_prod <= P_W'(i_data) * P_W'(i_mult);
            r_v1   <= i_valid;
            r_l1   <= i_last;
        end
    end

    // One guard bit above the product keeps the rounding add from overflowing.
    always_comb begin
        w_half = '0;
        if (i_shift != '0) begin
            w_half[i_shift - 1'b1] = 1'b1;
        end
        w_rnd = (P_W + 1)'(r_prod) + w_half;
        w_r   = w_rnd >>> i_shift;
        w_y   = (P_W + 2)'(w_r) + (P_W + 2)'(i_zp);
        if (w_y > SAT_HI) begin
            w_sat = SAT_HI[OUT_W-1:0];
        end else if (w_y < SAT_LO) begin
            w_sat = SAT_LO[OUT_W-1:0];
        end else begin
            w_sat = w_y[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_en) begin
            o_data  <= w_sat;
            o_valid <= r_v1;
            o_last  <= r_l1;
        end
    end

endmodule

// File: rtl/noc_requant_stage.sv
// Requantization stage between the MM core and GELU: job FSM, element counter,
// stream handshake and stream-framing error tracking around requant_core.
//   state    | meaning
//   ST_IDLE  | waiting for start, input not ready
//   ST_RUN   | accepting NUM_ELEMS input beats
//   ST_FLUSH | all beats taken, draining pipeline until the last output leaves
//   ST_DONE  | one-cycle done pulse, then back to idle
module noc_requant_stage
    import noc_pkg::*;
#(
    parameter int IN_W      = NOC_IN_W,
    parameter int OUT_W     = NOC_OUT_W,
    parameter int MULT_W    = NOC_MULT_W,
    parameter int NUM_ELEMS = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [MULT_W-1:0] cfg_mult,
    input  logic [NOC_SHIFT_W-1:0]   cfg_shift,
    input  logic signed [OUT_W-1:0]  cfg_zp,
    input  logic signed [IN_W-1:0]   s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic signed [OUT_W-1:0]  m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int CNT_W = $clog2(NUM_ELEMS + 1);
    localparam logic [CNT_W-1:0] N_ELEMS  = CNT_W'(NUM_ELEMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);

    noc_state_t                r_state;
    logic [CNT_W-1:0]          r_count;
    logic signed [MULT_W-1:0]  r_mult;
    logic [NOC_SHIFT_W-1:0]    r_shift;
    logic signed [OUT_W-1:0]   r_zp;
    logic                      r_error;
    logic                      w_adv;
    logic                      w_accept;
    logic                      w_is_last;

    assign w_adv     = !(m_tvalid && !m_tready);
    assign s_tready  = (r_state == ST_RUN) && w_adv && (r_count < N_ELEMS);
    assign w_accept  = s_tvalid && s_tready;
    assign w_is_last = (r_count == LAST_IDX);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done      = (r_state == ST_DONE);
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mult  <= '0;
            r_shift <= '0;
            r_zp    <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_mult  <= cfg_mult;
                        r_shift <= cfg_shift;
                        r_zp    <= cfg_zp;
                        r_count <= '0;
                        r_error <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Completion follows the count; s_tlast only flags framing errors.
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        if (s_tlast != w_is_last) begin
                            r_error <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    requant_core #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .MULT_W (MULT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_valid (w_accept),
        .i_last  (w_is_last),
        .i_data  (s_tdata),
        .i_mult  (r_mult),
        .i_shift (r_shift),
        .i_zp    (r_zp),
        .o_data  (m_tdata),
        .o_valid (m_tvalid),
        .o_last  (m_tlast)
    );

endmodule
